// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, key-word bit indices and FSM states for the PS/2 scancode receiver.
`timescale 1ns/1ps
package ps2_pkg;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_OVR0   = 8'h00;
   localparam logic [7:0] PS2_OVR1   = 8'hFF;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam int KEY_TOGGLE  = 10;
   localparam int KEY_PRESSED = 9;
   localparam int KEY_EXT     = 8;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
   // BAT-OK (AA) only counts as noise when no prefix is pending
   function automatic logic is_discard(input logic [7:0] b, input logic pending);
      return (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND) ||
             (b == PS2_OVR0) || (b == PS2_OVR1) || (b == PS2_BAT && !pending);
   endfunction
endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: PS/2 pins in, 11-bit key event word and status pulses out.
`timescale 1ns/1ps
interface ps2_scancode_rx_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] PS2_Key;
   logic        key_valid;
   logic        frame_err;
   modport master (output ps2_clk, ps2_data, input PS2_Key, key_valid, frame_err);
   modport slave  (input ps2_clk, ps2_data, output PS2_Key, key_valid, frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus FILTER_LEN stability filter with a registered falling-edge pulse.
`timescale 1ns/1ps
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic CLK_14M,
   input  logic reset_n,
   input  logic pin,
   output logic level,
   output logic fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   always_ff @(posedge CLK_14M or negedge reset_n) begin
      if (!reset_n) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], pin};
         fall <= 1'b0;
         // any sample agreeing with the current level restarts the run
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync[1];
            fall  <= level;
            cnt   <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: deframes PS/2 set-2 scancodes into the toggling 11-bit PS2_Key event word.
`timescale 1ns/1ps
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 2048
) (
   input logic              CLK_14M,
   input logic              reset_n,
   ps2_scancode_rx_if.slave bus
);
   localparam logic [11:0] TMO = 12'(TIMEOUT_CYC);
   logic       clk_lvl, clk_fall, clk_q, d_lvl, unused_data_fall;
   ps2_state_e state;
   logic [2:0]  bitcnt, pause_cnt;
   logic [7:0]  sr;
   logic        par, byte_rdy, ext, rel, valid, err;
   logic [11:0] idle_cnt;
   logic [10:0] key;
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
      .CLK_14M(CLK_14M), .reset_n(reset_n), .pin(bus.ps2_clk), .level(clk_lvl), .fall(clk_fall)
   );
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data (
      .CLK_14M(CLK_14M), .reset_n(reset_n), .pin(bus.ps2_data), .level(d_lvl), .fall(unused_data_fall)
   );
   always_ff @(posedge CLK_14M or negedge reset_n) begin
      if (!reset_n) begin
         clk_q    <= 1'b1;
         idle_cnt <= '0;
      end else begin
         clk_q    <= clk_lvl;
         idle_cnt <= (clk_lvl != clk_q) ? '0 : (idle_cnt == TMO) ? idle_cnt : idle_cnt + 1'b1;
      end
   end
   always_ff @(posedge CLK_14M or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bitcnt    <= '0;
         sr        <= '0;
         par       <= 1'b0;
         byte_rdy  <= 1'b0;
         ext       <= 1'b0;
         rel       <= 1'b0;
         pause_cnt <= '0;
         key       <= '0;
         valid     <= 1'b0;
         err       <= 1'b0;
      end else begin
         byte_rdy <= 1'b0;
         valid    <= 1'b0;
         err      <= 1'b0;
         // a clock edge takes priority over a coincident timeout
         if (clk_fall) begin
            case (state)
               IDLE: if (!d_lvl) begin
                  state  <= DATA;
                  bitcnt <= '0;
               end
               DATA: begin
                  sr     <= {d_lvl, sr[7:1]};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= d_lvl;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (d_lvl && ^{sr, par}) byte_rdy <= 1'b1;
                  else begin
                     err <= 1'b1;
                     ext <= 1'b0;
                     rel <= 1'b0;
                  end
               end
            endcase
         end else if (state != IDLE && idle_cnt == TMO) state <= IDLE;
         if (byte_rdy) begin
            if (pause_cnt != 3'd0) pause_cnt <= pause_cnt - 1'b1;
            else if (sr == PS2_PAUSE) pause_cnt <= 3'd7;
            else if (sr == PS2_EXT) ext <= 1'b1;
            else if (sr == PS2_REL) rel <= 1'b1;
            else if (!is_discard(sr, ext | rel)) begin
               key[KEY_TOGGLE]  <= ~key[KEY_TOGGLE];
               key[KEY_PRESSED] <= ~rel;
               key[KEY_EXT]     <= ext;
               key[7:0]         <= sr;
               valid            <= 1'b1;
               ext              <= 1'b0;
               rel              <= 1'b0;
            end
         end
      end
   end
   assign bus.PS2_Key   = key;
   assign bus.key_valid = valid;
   assign bus.frame_err = err;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: table-driven scancode vectors plus hand-written error, timeout, glitch and reset sequences.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;
   logic CLK_14M = 1'b0;
   logic reset_n = 1'b0;
   int   ev_cnt = 0, err_cnt = 0, passed = 0, total = 0;
   ps2_scancode_rx_if bus();
   ps2_scancode_rx dut (.CLK_14M(CLK_14M), .reset_n(reset_n), .bus(bus));
   always #34.921 CLK_14M = ~CLK_14M;
   always @(negedge CLK_14M) begin
      if (bus.key_valid) ev_cnt++;
      if (bus.frame_err) err_cnt++;
   end
   typedef struct {
      logic [7:0]  code;
      logic [10:0] key;
      int          ev;
   } vec_t;
   vec_t vecs[19];
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask
   // nbits < 11 truncates the frame after that many bits (start counts as bit 0)
   task automatic send(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         #2500;
         bus.ps2_clk = 1'b0;
         #5000;
         bus.ps2_clk = 1'b1;
         #2500;
      end
      bus.ps2_data = 1'b1;
      #20000;
   endtask
   initial begin
      vecs = '{
         '{8'h1C, 11'h61C, 1}, '{8'hF0, 11'h61C, 1}, '{8'h1C, 11'h01C, 2},
         '{8'hE0, 11'h01C, 2}, '{8'h75, 11'h775, 3},
         '{8'hE0, 11'h775, 3}, '{8'hF0, 11'h775, 3}, '{8'h75, 11'h175, 4},
         '{8'hAA, 11'h175, 4}, '{8'hFA, 11'h175, 4},
         '{8'hE1, 11'h175, 4}, '{8'h14, 11'h175, 4}, '{8'h77, 11'h175, 4}, '{8'hE1, 11'h175, 4},
         '{8'hF0, 11'h175, 4}, '{8'h14, 11'h175, 4}, '{8'hF0, 11'h175, 4}, '{8'h77, 11'h175, 4},
         '{8'h1C, 11'h61C, 5}
      };
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      #200;
      check("reset_key", bus.PS2_Key, 0);
      check("reset_valid", bus.key_valid, 0);
      check("reset_err", bus.frame_err, 0);
      @(negedge CLK_14M) reset_n = 1'b1;
      #2000;
      for (int i = 0; i < 19; i++) begin
         send(vecs[i].code, 1'b0, 11);
         check($sformatf("vec%0d_key", i), bus.PS2_Key, vecs[i].key);
         check($sformatf("vec%0d_events", i), ev_cnt, vecs[i].ev);
      end
      check("no_err_after_table", err_cnt, 0);
      send(8'hE0, 1'b0, 11);
      send(8'h1C, 1'b1, 11);
      check("parity_err_count", err_cnt, 1);
      check("parity_key_hold", bus.PS2_Key, 11'h61C);
      check("parity_no_event", ev_cnt, 5);
      send(8'h1C, 1'b0, 11);
      check("after_err_key", bus.PS2_Key, 11'h21C);
      check("after_err_events", ev_cnt, 6);
      send(8'h1C, 1'b0, 5);
      #200000;
      send(8'h1C, 1'b0, 11);
      check("timeout_key", bus.PS2_Key, 11'h61C);
      check("timeout_events", ev_cnt, 7);
      check("timeout_no_err", err_cnt, 1);
      for (int i = 0; i < 5; i++) begin
         bus.ps2_clk = 1'b0;
         #100;
         bus.ps2_clk = 1'b1;
         #2000;
      end
      check("glitch_key", bus.PS2_Key, 11'h61C);
      check("glitch_events", ev_cnt, 7);
      send(8'h1C, 1'b0, 11);
      check("post_glitch_key", bus.PS2_Key, 11'h21C);
      check("post_glitch_events", ev_cnt, 8);
      send(8'h1C, 1'b0, 4);
      reset_n = 1'b0;
      #1;
      check("midreset_key", bus.PS2_Key, 0);
      check("midreset_valid", bus.key_valid, 0);
      check("midreset_err", bus.frame_err, 0);
      #500;
      @(negedge CLK_14M) reset_n = 1'b1;
      #2000;
      send(8'h1C, 1'b0, 11);
      check("post_reset_key", bus.PS2_Key, 11'h61C);
      check("post_reset_events", ev_cnt, 9);
      check("final_err_count", err_cnt, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
